// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and the
// control word produced by the state decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StRwb, StIExec, StIwb, StBranch, StJump, StHalt
  } state_e;

  typedef enum logic [1:0] {AluAdd = 2'b00, AluSub = 2'b01, AluFunct = 2'b10} alu_op_e;
  typedef enum logic [1:0] {SrcBReg, SrcBFour, SrcBImm, SrcBImmSh} alu_src_b_e;
  typedef enum logic [1:0] {PcAlu, PcAluOut, PcJump} pc_source_e;

  // *_rdy fields only take effect on the cycle the memory reports ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_rdy;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write_rdy;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       retire;
    logic       retire_rdy;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multi-cycle controller and the datapath/memory.
interface multicycle_control_if;

  logic [5:0]  Op;
  logic        Zero;
  logic        MemReady;
  logic        PCEn;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        Retire;
  logic [31:0] InstrCount;
  logic        Halted;

  modport master (
    input  Op, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Retire, InstrCount, Halted
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Retire, InstrCount, Halted
  );

endinterface

// File: rtl/mc_outdecode.sv
// Combinational state-to-control-word decoder for the multi-cycle controller.
module mc_outdecode
  import mips_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read     = 1'b1;
        ctrl_o.alu_src_b    = SrcBFour;
        ctrl_o.pc_write_rdy = 1'b1;
        ctrl_o.ir_write_rdy = 1'b1;
      end
      StDecode: ctrl_o.alu_src_b = SrcBImmSh;
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      StMemWr: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.retire_rdy = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = AluFunct;
      end
      StRwb: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StIExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StIwb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = AluSub;
        ctrl_o.pc_source = PcAluOut;
        ctrl_o.branch    = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_source = PcJump;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StHalt: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath with retired-instruction counter.
// Outputs are held low combinationally while reset is asserted.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                        CLK,
  input  logic                        reset,
  multicycle_control_if.master        mc_if
);

  state_e      state_q, state_d;
  logic        bne_q, bne_d;
  logic        sw_q, sw_d;
  logic [31:0] instr_count_q, instr_count_d;
  ctrl_t       ctrl;
  logic        pc_en;
  logic        retire;

  mc_outdecode u_outdecode (
    .state_i(state_q),
    .ctrl_o (ctrl)
  );

  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    sw_d    = sw_q;
    unique case (state_q)
      StFetch: begin
        bne_d = 1'b0;
        sw_d  = 1'b0;
        if (mc_if.MemReady) state_d = StDecode;
      end
      StDecode: begin
        bne_d = (mc_if.Op == OP_BNE);
        sw_d  = (mc_if.Op == OP_SW);
        case (mc_if.Op)
          OP_RTYPE:      state_d = StExec;
          OP_LW, OP_SW:  state_d = StMemAdr;
          OP_ADDI:       state_d = StIExec;
          OP_BEQ, OP_BNE: state_d = StBranch;
          OP_J:          state_d = StJump;
          default:       state_d = StHalt;
        endcase
      end
      StMemAdr: state_d = sw_q ? StMemWr : StMemRd;
      StMemRd:  if (mc_if.MemReady) state_d = StMemWb;
      StMemWr:  if (mc_if.MemReady) state_d = StFetch;
      StExec:   state_d = StRwb;
      StIExec:  state_d = StIwb;
      StMemWb, StRwb, StIwb, StBranch, StJump: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_en = ctrl.pc_write
          | (ctrl.pc_write_rdy & mc_if.MemReady)
          | (ctrl.branch & (bne_q ? ~mc_if.Zero : mc_if.Zero));
    retire = ctrl.retire | (ctrl.retire_rdy & mc_if.MemReady);
    instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= StFetch;
      bne_q         <= 1'b0;
      sw_q          <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      bne_q         <= bne_d;
      sw_q          <= sw_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Gating by reset suppresses in-flight requests without waiting for a clock edge.
  assign mc_if.PCEn       = reset & pc_en;
  assign mc_if.IorD       = reset & ctrl.iord;
  assign mc_if.MemRead    = reset & ctrl.mem_read;
  assign mc_if.MemWrite   = reset & ctrl.mem_write;
  assign mc_if.IRWrite    = reset & ctrl.ir_write_rdy & mc_if.MemReady;
  assign mc_if.MemtoReg   = reset & ctrl.mem_to_reg;
  assign mc_if.RegDst     = reset & ctrl.reg_dst;
  assign mc_if.RegWrite   = reset & ctrl.reg_write;
  assign mc_if.ALUSrcA    = reset & ctrl.alu_src_a;
  assign mc_if.ALUSrcB    = {2{reset}} & ctrl.alu_src_b;
  assign mc_if.ALUOp      = {2{reset}} & ctrl.alu_op;
  assign mc_if.PCSource   = {2{reset}} & ctrl.pc_source;
  assign mc_if.Retire     = reset & retire;
  assign mc_if.InstrCount = {32{reset}} & instr_count_q;
  assign mc_if.Halted     = reset & ctrl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: tabled instructions, randomized instruction stream with a
// per-instruction behavioural model, and hand-written reset/halt/wrap sequences.
module tb_multicycle_control;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_count = 32'd0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .CLK  (clk),
    .reset(rst_n),
    .mc_if(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    int         wf;
    int         wm;
    int         zsel;
    int         exp_cycles;
    int         exp_regw;
    int         exp_pcen;
  } vec_t;

  vec_t       vecs[12];
  logic [5:0] legal_ops[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SW: return 4;
      OP_LW:                    return 5;
      default:                  return 3;
    endcase
  endfunction

  function automatic logic [16:0] all_outputs();
    return {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
            bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.Retire, bus.Halted};
  endfunction

  // Runs one instruction starting in FETCH; memory answers after wf (fetch) or wm (data)
  // wait cycles. zsel: 0/1 fixed Zero, 2 random Zero.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int zsel,
                           output int cycles, output int regw, output int pcen);
    int         waited = 0;
    int         memr = 0;
    int         memw = 0;
    int         irw = 0;
    logic       z = 1'b0;
    logic       done = 1'b0;
    logic       last_regdst = 1'b0;
    logic       last_m2r = 1'b0;
    logic [1:0] last_pcsrc = 2'b00;
    int         exp_pcen;
    logic       writes_reg;
    cycles = 0;
    regw   = 0;
    pcen   = 0;
    bus.Op = op;
    while (!done && cycles < 64) begin
      @(negedge clk);
      z = (zsel == 2) ? 1'($urandom) : (zsel == 1);
      bus.Zero = z;
      if (bus.MemRead || bus.MemWrite) begin
        bus.MemReady = (waited == (bus.IorD ? wm : wf));
        waited = bus.MemReady ? 0 : waited + 1;
      end else begin
        bus.MemReady = 1'($urandom);
      end
      #1;
      cycles++;
      memr += int'(bus.MemRead);
      memw += int'(bus.MemWrite);
      irw  += int'(bus.IRWrite);
      regw += int'(bus.RegWrite);
      pcen += int'(bus.PCEn);
      if (bus.Retire) begin
        done        = 1'b1;
        last_regdst = bus.RegDst;
        last_m2r    = bus.MemtoReg;
        last_pcsrc  = bus.PCSource;
      end
    end
    check("retire_seen", 32'(done), 32'd1);
    writes_reg = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW);
    exp_pcen = 1 + int'(op == OP_J) + int'(op == OP_BEQ && z) + int'(op == OP_BNE && !z);
    check("cycles", cycles, base_cycles(op) + wf + ((op == OP_LW || op == OP_SW) ? wm : 0));
    check("ir_write_pulses", irw, 1);
    check("mem_read_cycles", memr, wf + 1 + ((op == OP_LW) ? wm + 1 : 0));
    check("mem_write_cycles", memw, (op == OP_SW) ? wm + 1 : 0);
    check("reg_write_pulses", regw, writes_reg ? 1 : 0);
    check("pc_en_pulses", pcen, exp_pcen);
    check("last_pcsource", 32'(last_pcsrc),
          (op == OP_BEQ || op == OP_BNE) ? 1 : (op == OP_J) ? 2 : 0);
    if (writes_reg) begin
      check("reg_dst", 32'(last_regdst), 32'(op == OP_RTYPE));
      check("mem_to_reg", 32'(last_m2r), 32'(op == OP_LW));
    end
    @(posedge clk);
    #1;
    exp_count = exp_count + 32'd1;
    check("instr_count", bus.InstrCount, exp_count);
  endtask

  initial begin
    int cyc, rw, pc;
    logic seen;

    vecs[0]  = '{OP_RTYPE, 0, 0, 2, 4, 1, 1};
    vecs[1]  = '{OP_ADDI,  0, 0, 2, 4, 1, 1};
    vecs[2]  = '{OP_LW,    0, 0, 2, 5, 1, 1};
    vecs[3]  = '{OP_LW,    2, 3, 2, 10, 1, 1};
    vecs[4]  = '{OP_SW,    0, 0, 2, 4, 0, 1};
    vecs[5]  = '{OP_SW,    1, 2, 2, 7, 0, 1};
    vecs[6]  = '{OP_BEQ,   0, 0, 1, 3, 0, 2};
    vecs[7]  = '{OP_BNE,   0, 0, 1, 3, 0, 1};
    vecs[8]  = '{OP_BNE,   0, 0, 0, 3, 0, 2};
    vecs[9]  = '{OP_BEQ,   0, 0, 0, 3, 0, 1};
    vecs[10] = '{OP_J,     0, 0, 2, 3, 0, 2};
    vecs[11] = '{OP_RTYPE, 3, 0, 2, 7, 1, 1};
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J};

    bus.Op = 6'h00;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(all_outputs()), 32'd0);
    check("reset_count", bus.InstrCount, 32'd0);

    @(negedge clk);
    bus.MemReady = 1'b0;
    rst_n = 1'b1;
    #1;
    check("fetch_after_reset", {bus.MemRead, bus.IorD, bus.ALUSrcB}, 4'b1001);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].wf, vecs[i].wm, vecs[i].zsel, cyc, rw, pc);
      check("vec_cycles", cyc, vecs[i].exp_cycles);
      check("vec_reg_write", rw, vecs[i].exp_regw);
      check("vec_pc_en", pc, vecs[i].exp_pcen);
    end

    for (int n = 0; n < 30; n++) begin
      run_instr(legal_ops[$urandom_range(6, 0)], int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 2, cyc, rw, pc);
    end

    // Illegal opcode parks the controller until reset.
    bus.Op = 6'h3F;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bus.MemReady = 1'b1;
      #1;
      seen = bus.Halted;
    end
    check("halt_reached", 32'(seen), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.MemReady = 1'($urandom);
      bus.Zero = 1'($urandom);
      #1;
      check("halt_enables", {bus.PCEn, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                             bus.Retire, bus.Halted}, 7'b0000001);
      check("halt_count", bus.InstrCount, exp_count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.MemReady = 1'b0;
    #1;
    check("halt_reset_outputs", 32'(all_outputs()), 32'd0);
    exp_count = 32'd0;
    check("halt_reset_count", bus.InstrCount, exp_count);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("fetch_after_halt", {bus.MemRead, bus.IorD, bus.ALUSrcB, bus.Halted}, 5'b10010);

    // Reset while a store waits on memory.
    bus.Op = OP_SW;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      bus.MemReady = !bus.MemWrite;
      #1;
      seen = bus.MemWrite;
    end
    check("mem_write_wait", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mem_write_dropped", {bus.MemWrite, bus.Retire}, 2'b00);
    @(posedge clk);
    #1;
    check("abort_count", bus.InstrCount, 32'd0);
    @(negedge clk);
    bus.MemReady = 1'b0;
    rst_n = 1'b1;

    // Counter wrap: preload all-ones while FETCH waits, then retire a jump.
    @(negedge clk);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instr_count_q;
    exp_count = 32'hFFFF_FFFF;
    #1;
    check("preload_count", bus.InstrCount, exp_count);
    run_instr(OP_J, 0, 0, 2, cyc, rw, pc);
    check("wrap_count", bus.InstrCount, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. Sequences one shared memory, the IR, the register file, the single ALU and the PC through fetch, decode, execute, memory and writeback steps. Waits on a memory-ready handshake for every memory access. Reports retired instructions and halts on an illegal opcode.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; forces FETCH state, zero counters, write enables low
- Op  in  6  IR[31:26]; sampled only in DECODE
- Zero  in  1  ALU zero flag; used only in BRANCH
- MemReady  in  1  memory completes the current access this cycle
- PCEn  out  1  PC load enable: PCWrite | (beq & Zero) | (bne & ~Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR from memory data
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  write register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = reg A
- ALUSrcB  out  2  ALU B: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- Retire  out  1  one-cycle pulse on the last cycle of each instruction
- InstrCount  out  32  retired-instruction counter, wraps 0xFFFFFFFF -> 0
- Halted  out  1  high in HALT

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IEXEC, IWB, BRANCH, JUMP, HALT.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCEn are asserted only when MemReady=1. Go to DECODE on MemReady, otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 0x00 -> EXEC
  - 0x23, 0x2B -> MEMADR
  - 0x08 -> IEXEC
  - 0x04, 0x05 -> BRANCH (beq/bne flag latched)
  - 0x02 -> JUMP
  - other -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Wait for MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, Retire. Then FETCH.
- MEMWR: IorD=1, MemWrite=1. Wait for MemReady. Retire on the ready cycle, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, Retire. Then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, Retire. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCEn is Zero for beq and ~Zero for bne. Retire. Then FETCH.
- JUMP: PCSource=10, PCEn=1, Retire. Then FETCH.
- HALT: all enables 0, Halted=1. Stays until reset.
- Unlisted outputs are 0 in every state. The branch flag is internal and is cleared in FETCH.
- InstrCount increments by 1 on each Retire.

## Timing
- Moore outputs decoded from the state register, except PCEn, which also depends on Zero in BRANCH. IRWrite, PCEn and Retire in FETCH/MEMWR are also gated by MemReady.
- While reset=0: state=FETCH, InstrCount=0, branch flag=0. All outputs are forced to 0, including MemRead, Retire and Halted.
- After reset deasserts, the first rising edge evaluates FETCH.
- Latency with MemReady held 1:
  - R-type: 4 cycles
  - addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - j: 3 cycles
- Each wait cycle adds exactly one cycle. Requests are held stable while waiting, and no side effect occurs until the ready cycle.
- Reset mid-instruction aborts it with no retire. In-flight writes are suppressed immediately (asynchronous).
- MemReady outside FETCH/MEMRD/MEMWR is ignored.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J)
  - state encoding, 4-bit
  - ALUOp, ALUSrcB and PCSource encodings
- ALUcontrol consumes ALUOp unchanged.
- One sub-module, mc_outdecode: a combinational state-to-control-word decoder. The FSM and counter stay in multicycle_control.

## Test plan
- Op=0x00, MemReady=1 -> states FETCH, DECODE, EXEC, RWB. RegWrite=1 and RegDst=1 only in cycle 4. Retire once; InstrCount 0 -> 1.
- Op=0x23 with MemReady low for 2 cycles in FETCH and 3 in MEMRD -> total 10 cycles. IRWrite and PCEn pulse only on the FETCH ready cycle. MemWB asserts RegWrite=1 and MemtoReg=1.
- Branch sequence:
  - Op=0x04, Zero=1 -> PCEn=1 with PCSource=01 in BRANCH.
  - Op=0x05, Zero=1 -> PCEn=0.
  - Op=0x05, Zero=0 -> PCEn=1.
  - Each takes 3 cycles.
- Op=0x3F -> HALT. Halted=1, all enables 0 for 20 cycles, InstrCount unchanged. Reset low then high -> back in FETCH.
- Assert reset during MEMWR while waiting -> MemWrite drops to 0 in the same cycle. No Retire; InstrCount=0.
- Preload InstrCount to 0xFFFFFFFF via 2^32-1 forced retires (or force) -> next j retire gives 0x00000000.
